ip_rx_crpr_acc: RTL and testbench
=================================

IP_RX_CRPR_ACC -- requirements
Module: ip_rx_crpr_acc

Interface
REQ-001 SHALL provide parameter DW, default 16, RX datapath width; legal values 16 and 64 only.
REQ-002 SHALL provide parameter BAR_MASK, default 7'b0000011; memory TLPs hitting any masked BAR are consumed locally and return no credits.
REQ-003 SHALL provide parameter PD_W, default 12, width of the posted-data accumulator.
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-005 SHALL have ports: rx_st in 1 first beat of TLP; rx_end in 1 last beat; rx_din in DW TLP data; rx_bar_hit in 7 one-hot BAR hit, valid with rx_st.
REQ-006 SHALL have ports: cr_valid out 1 credits pending; cr_ready in 1 consumer accepts; cr_ph out 8; cr_pd out PD_W; cr_nph out 8; cr_npd out 8 (accumulated credit counts).
REQ-007 SHALL have ports: cr_ovf out 1 sticky saturation flag; rx_err out 1 one-cycle pulse on protocol error.

Function
REQ-008 SHALL decode fmt/type from rx_din[DW-1:DW-8] on the rx_st beat.
REQ-009 Decode: MRd 00x0_0000 -> 1 NPH unless masked; MRdLk 00x0_0001 -> 1 NPH; MWr 01x0_0000 -> 1 PH + data PD unless masked; IORd 0x02, CfgRd 0x04/0x05 -> 1 NPH; IOWr 0x42, CfgWr 0x44/0x45 -> 1 NPH + 1 NPD; Msg 0011_0xxx -> 1 PH; MsgD 0111_0xxx -> 1 PH + data PD; all else -> no credits.
REQ-010 "Masked" SHALL mean (rx_bar_hit & BAR_MASK) != 0.
REQ-011 Length SHALL be the 10-bit DW length field: DW=16 -> rx_din[9:0] of beat after rx_st; DW=64 -> rx_din[41:32] of rx_st beat.
REQ-012 PD for a TLP SHALL be ceil(len/4) in 9 bits; len==0 means 1024 DW -> 256.
REQ-013 FSM states IDLE, LEN, WAIT; IDLE + rx_st -> LEN if DW=16 and PD needed, else WAIT; LEN -> WAIT after one beat; WAIT + rx_end -> IDLE.
REQ-014 rx_st and rx_end in the same cycle SHALL complete the TLP that cycle (IDLE -> IDLE), length taken from that beat when DW=64.
REQ-015 Per-TLP credits SHALL be held internally and committed to the accumulators only in the rx_end cycle.
REQ-016 rx_st received in LEN or WAIT SHALL discard the pending TLP's credits, pulse rx_err, and restart decode on the new TLP.
REQ-017 rx_end in IDLE without rx_st SHALL be ignored and pulse rx_err.
REQ-018 cr_ph/cr_pd/cr_nph/cr_npd SHALL be the accumulator registers directly; cr_valid SHALL be high whenever any accumulator is nonzero.
REQ-019 Handshake (cr_valid & cr_ready): accumulators SHALL load that cycle's commit amount (zero if none); no commit is ever lost.
REQ-020 Without handshake, accumulators SHALL add the commit amount; values may grow while cr_valid is high and the consumer takes values on the handshake cycle.
REQ-021 Each accumulator SHALL saturate at all-ones; any saturating add SHALL set cr_ovf until reset.
REQ-022 Commit latency: credits visible on cr_* the cycle after rx_end.
REQ-023 cr_ready SHALL have no effect when cr_valid is low.

Reset
REQ-024 rst SHALL force FSM to IDLE, clear pending per-TLP credits, all accumulators, cr_valid, cr_ovf and rx_err, next edge.
REQ-025 rst mid-TLP SHALL discard that TLP; a subsequent rx_end before rx_st SHALL count as REQ-017 error.

Verification
REQ-026 DW=16, MWr 0x40, bar_hit 7'b0000100, len 10, cr_ready=0 -> after rx_end cr_ph=1, cr_pd=3, cr_valid=1.
REQ-027 DW=16, MRd 0x00 with bar_hit 7'b0000001 -> no credits, cr_valid stays 0; same with bar_hit 7'b0001000 -> cr_nph=1.
REQ-028 DW=64, MsgD 0x70, len 0 -> cr_ph=1, cr_pd=256; CfgWr0 0x44 -> cr_nph=1, cr_npd=1.
REQ-029 cr_ready=1 same cycle a CfgRd commits, accumulators nph=3 -> handshake takes 3, next cycle cr_nph=1.
REQ-030 300 back-to-back Msg TLPs, cr_ready=0 -> cr_ph=255, cr_ovf=1; rx_st in WAIT -> rx_err pulse, first TLP uncounted.

Source files
------------

// File: rtl/ip_rx_crpr_acc.sv
// ip_rx_crpr_acc: decodes received TLPs into PH/PD/NPH/NPD credits and accumulates them for a consumer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_st, rx_end            first / last beat of a TLP
//   rx_din                   TLP data (fmt/type in the top byte of the rx_st beat)
//   rx_bar_hit               one-hot BAR hit, valid with rx_st
//   cr_valid, cr_ready       credit handshake
//   cr_ph, cr_pd, cr_nph, cr_npd  accumulated credit counts
//   cr_ovf                   sticky saturation flag
//   rx_err                   one-cycle protocol error pulse
module ip_rx_crpr_acc #(
    parameter int         DW       = 16,
    parameter logic [6:0] BAR_MASK = 7'b0000011,
    parameter int         PD_W     = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx_st,
    input  logic            rx_end,
    input  logic [DW-1:0]   rx_din,
    input  logic [6:0]      rx_bar_hit,
    output logic            cr_valid,
    input  logic            cr_ready,
    output logic [7:0]      cr_ph,
    output logic [PD_W-1:0] cr_pd,
    output logic [7:0]      cr_nph,
    output logic [7:0]      cr_npd,
    output logic            cr_ovf,
    output logic            rx_err
);
    localparam int LO = (DW == 64) ? 32 : 0;
    typedef enum logic [1:0] {IDLE, LEN, WAIT} state_t;
    state_t state;
    logic [7:0] ft, fm;
    logic masked, is_mrd, is_lk, is_mwr, is_nprd, is_npwr, is_msg, is_msgd;
    logic d_ph, d_nph, d_npd, d_need;
    logic [9:0] len;
    logic [10:0] len_r;
    logic [8:0] pd_now;
    logic p_ph, p_nph, p_npd;
    logic [8:0] p_pd;
    logic commit, c_ph, c_nph, c_npd, hs;
    logic [8:0] c_pd, s_ph, s_nph, s_npd;
    logic [PD_W:0] s_pd;
    logic unused;
    assign unused = ^rx_din;
    assign cr_valid = |{cr_ph, cr_pd, cr_nph, cr_npd};
    always_comb begin
        ft      = rx_din[DW-1:DW-8];
        fm      = ft & 8'hdf;
        masked  = |(rx_bar_hit & BAR_MASK);
        is_mrd  = fm == 8'h00;
        is_lk   = fm == 8'h01;
        is_mwr  = fm == 8'h40;
        is_nprd = ft == 8'h02 || ft == 8'h04 || ft == 8'h05;
        is_npwr = ft == 8'h42 || ft == 8'h44 || ft == 8'h45;
        is_msg  = ft[7:3] == 5'b00110;
        is_msgd = ft[7:3] == 5'b01110;
        d_ph    = (is_mwr && !masked) || is_msg || is_msgd;
        d_need  = (is_mwr && !masked) || is_msgd;
        d_nph   = (is_mrd && !masked) || is_lk || is_nprd || is_npwr;
        d_npd   = is_npwr;
        len     = rx_din[LO+9:LO];
        len_r   = {1'b0, len} + 11'd3;
        pd_now  = (len == 10'd0) ? 9'd256 : len_r[10:2];
        // a lone rx_end in IDLE is an error, never a commit
        commit  = rx_end && (rx_st || state != IDLE);
        c_ph    = commit && (rx_st ? d_ph : p_ph);
        c_nph   = commit && (rx_st ? d_nph : p_nph);
        c_npd   = commit && (rx_st ? d_npd : p_npd);
        c_pd    = !commit ? 9'd0 : rx_st ? (d_need ? pd_now : 9'd0) : (state == LEN) ? pd_now : p_pd;
        hs      = cr_valid && cr_ready;
        s_ph    = {1'b0, cr_ph} + 9'(c_ph);
        s_nph   = {1'b0, cr_nph} + 9'(c_nph);
        s_npd   = {1'b0, cr_npd} + 9'(c_npd);
        s_pd    = {1'b0, cr_pd} + (PD_W+1)'(c_pd);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            p_ph   <= 1'b0;
            p_nph  <= 1'b0;
            p_npd  <= 1'b0;
            p_pd   <= '0;
            cr_ph  <= '0;
            cr_pd  <= '0;
            cr_nph <= '0;
            cr_npd <= '0;
            cr_ovf <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            rx_err <= rx_st ? state != IDLE : rx_end && state == IDLE;
            // a new rx_st always restarts decode, dropping any pending TLP
            if (rx_st) begin
                p_ph  <= d_ph;
                p_nph <= d_nph;
                p_npd <= d_npd;
                p_pd  <= d_need ? pd_now : 9'd0;
                state <= rx_end ? IDLE : (DW == 16 && d_need) ? LEN : WAIT;
            end else if (state == LEN) begin
                p_pd  <= pd_now;
                state <= rx_end ? IDLE : WAIT;
            end else if (state == WAIT && rx_end) begin
                state <= IDLE;
            end
            // the handshake hands the whole count over and restarts from this cycle's commit
            cr_ph  <= hs ? 8'(c_ph) : s_ph[8] ? 8'hff : s_ph[7:0];
            cr_nph <= hs ? 8'(c_nph) : s_nph[8] ? 8'hff : s_nph[7:0];
            cr_npd <= hs ? 8'(c_npd) : s_npd[8] ? 8'hff : s_npd[7:0];
            cr_pd  <= hs ? PD_W'(c_pd) : s_pd[PD_W] ? '1 : s_pd[PD_W-1:0];
            cr_ovf <= cr_ovf || (!hs && (s_ph[8] || s_nph[8] || s_npd[8] || s_pd[PD_W]));
        end
    end
endmodule

// File: tb/tb_ip_rx_crpr_acc.sv
// tb_ip_rx_crpr_acc: random and directed checks of ip_rx_crpr_acc at DW=16 and DW=64 against a TLP-level credit model.
module tb_ip_rx_crpr_acc;
    localparam logic [6:0] MASK = 7'b0000011;
    logic clk = 1'b0, rst = 1'b1;
    logic st[2], en[2], rdy[2];
    logic [6:0] bar[2];
    logic [15:0] din16;
    logic [63:0] din64;
    logic [7:0] o_ph[2], o_nph[2], o_npd[2];
    logic [11:0] o_pd[2];
    logic o_valid[2], o_ovf[2], o_err[2];
    int c_ph[2], c_pd[2], c_nph[2], c_npd[2];
    bit x_err[2], busy[2];
    int e_ph[2], e_pd[2], e_nph[2], e_npd[2];
    bit e_ovf[2], e_err[2];
    int total = 0, bad = 0, rmode = 0;
    logic [7:0] picks[12] = '{8'h00, 8'h20, 8'h01, 8'h40, 8'h60, 8'h02, 8'h04, 8'h05, 8'h42, 8'h44, 8'h33, 8'h75};

    always #5 clk = ~clk;

    ip_rx_crpr_acc #(.DW(16), .BAR_MASK(MASK), .PD_W(12)) u16 (
        .clk(clk), .rst(rst), .rx_st(st[0]), .rx_end(en[0]), .rx_din(din16), .rx_bar_hit(bar[0]),
        .cr_valid(o_valid[0]), .cr_ready(rdy[0]), .cr_ph(o_ph[0]), .cr_pd(o_pd[0]),
        .cr_nph(o_nph[0]), .cr_npd(o_npd[0]), .cr_ovf(o_ovf[0]), .rx_err(o_err[0]));
    ip_rx_crpr_acc #(.DW(64), .BAR_MASK(MASK), .PD_W(12)) u64 (
        .clk(clk), .rst(rst), .rx_st(st[1]), .rx_end(en[1]), .rx_din(din64), .rx_bar_hit(bar[1]),
        .cr_valid(o_valid[1]), .cr_ready(rdy[1]), .cr_ph(o_ph[1]), .cr_pd(o_pd[1]),
        .cr_nph(o_nph[1]), .cr_npd(o_npd[1]), .cr_ovf(o_ovf[1]), .rx_err(o_err[1]));

    function automatic int acc(input int a, input int c, input int mx, input bit hs, inout bit ov);
        if (hs) return c;
        if (a + c > mx) begin
            ov = 1'b1;
            return mx;
        end
        return a + c;
    endfunction

    // credit table for one whole TLP
    function automatic void cred(input logic [7:0] ft, input logic [6:0] b, input logic [9:0] len,
                                 output int ph, output int pd, output int nph, output int npd);
        bit m;
        int d;
        m = (b & MASK) != 0;
        d = (len == 0) ? 256 : (int'(len) + 3) / 4;
        ph = 0; pd = 0; nph = 0; npd = 0;
        if (ft == 8'h00 || ft == 8'h20) nph = m ? 0 : 1;
        else if (ft == 8'h01 || ft == 8'h21) nph = 1;
        else if (ft == 8'h40 || ft == 8'h60) begin
            if (!m) begin ph = 1; pd = d; end
        end
        else if (ft inside {8'h02, 8'h04, 8'h05}) nph = 1;
        else if (ft inside {8'h42, 8'h44, 8'h45}) begin nph = 1; npd = 1; end
        else if (ft >= 8'h30 && ft <= 8'h37) ph = 1;
        else if (ft >= 8'h70 && ft <= 8'h77) begin ph = 1; pd = d; end
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit hs;
            if (rst) begin
                e_ph[i] = 0; e_pd[i] = 0; e_nph[i] = 0; e_npd[i] = 0; e_ovf[i] = 0; e_err[i] = 0;
            end else begin
                hs = (e_ph[i] | e_pd[i] | e_nph[i] | e_npd[i]) != 0 && rdy[i];
                e_ph[i]  = acc(e_ph[i], c_ph[i], 255, hs, e_ovf[i]);
                e_pd[i]  = acc(e_pd[i], c_pd[i], 4095, hs, e_ovf[i]);
                e_nph[i] = acc(e_nph[i], c_nph[i], 255, hs, e_ovf[i]);
                e_npd[i] = acc(e_npd[i], c_npd[i], 255, hs, e_ovf[i]);
                e_err[i] = x_err[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp(input int i);
        chk($sformatf("ph%0d", i), 32'(o_ph[i]), e_ph[i]);
        chk($sformatf("pd%0d", i), 32'(o_pd[i]), e_pd[i]);
        chk($sformatf("nph%0d", i), 32'(o_nph[i]), e_nph[i]);
        chk($sformatf("npd%0d", i), 32'(o_npd[i]), e_npd[i]);
        chk($sformatf("valid%0d", i), 32'(o_valid[i]), 32'((e_ph[i] | e_pd[i] | e_nph[i] | e_npd[i]) != 0));
        chk($sformatf("ovf%0d", i), 32'(o_ovf[i]), 32'(e_ovf[i]));
        chk($sformatf("err%0d", i), 32'(o_err[i]), 32'(e_err[i]));
    endtask

    task automatic step(input int i, input bit s, input bit e, input logic [63:0] d, input logic [6:0] b,
                        input int ph, input int pd, input int nph, input int npd, input bit er);
        st[i] = s; en[i] = e; bar[i] = b;
        if (i == 0) din16 = d[15:0]; else din64 = d;
        rdy[i] = rmode == 1 ? 1'($urandom) : rmode == 2 ? 1'b1 : rmode == 3 ? e : 1'b0;
        c_ph[i] = ph; c_pd[i] = pd; c_nph[i] = nph; c_npd[i] = npd; x_err[i] = er;
        @(posedge clk);
        @(negedge clk);
        st[i] = 0; en[i] = 0; rdy[i] = 0;
        c_ph[i] = 0; c_pd[i] = 0; c_nph[i] = 0; c_npd[i] = 0; x_err[i] = 0;
        cmp(0);
        cmp(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy[0] = 0; busy[1] = 0;
        cmp(0);
        cmp(1);
    endtask

    task automatic send(input int i, input logic [7:0] ft, input logic [6:0] b, input logic [9:0] len,
                        input int nb, input bit trunc);
        int ph, pd, nph, npd;
        logic [63:0] d;
        bit last;
        cred(ft, b, len, ph, pd, nph, npd);
        for (int k = 0; k < nb; k++) begin
            d = {$urandom, $urandom};
            last = (k == nb - 1) && !trunc;
            if (i == 0) begin
                if (k == 0) d[15:8] = ft;
                if (k == 1) d[9:0] = len;
            end else if (k == 0) begin
                d[63:56] = ft;
                d[41:32] = len;
            end
            step(i, k == 0, last, d, k == 0 ? b : 7'($urandom), last ? ph : 0, last ? pd : 0,
                 last ? nph : 0, last ? npd : 0, k == 0 && busy[i]);
            if (k == 0) busy[i] = 1;
            if (last) busy[i] = 0;
        end
    endtask

    task automatic stray(input int i);
        step(i, 0, 1, {$urandom, $urandom}, 7'($urandom), 0, 0, 0, 0, 1);
    endtask

    task automatic rand_phase();
        int i, nb;
        logic [7:0] ft;
        logic [6:0] b;
        logic [9:0] len;
        for (int n = 0; n < 400; n++) begin
            i = $urandom_range(0, 1);
            ft = ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 11)];
            b = ($urandom_range(0, 2) == 0) ? 7'd0 : 7'(1 << $urandom_range(0, 6));
            case ($urandom_range(0, 5))
                0: len = 10'd0;
                1: len = 10'd1023;
                default: len = 10'($urandom);
            endcase
            nb = (i == 0) ? $urandom_range(2, 5) : $urandom_range(1, 4);
            if ($urandom_range(0, 49) == 0) do_reset();
            if ($urandom_range(0, 19) == 0 && !busy[i]) stray(i);
            if ($urandom_range(0, 9) == 0) step(i, 0, 0, {$urandom, $urandom}, 7'($urandom), 0, 0, 0, 0, 0);
            send(i, ft, b, len, nb, $urandom_range(0, 9) == 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            st[i] = 0; en[i] = 0; rdy[i] = 0; bar[i] = 0;
            c_ph[i] = 0; c_pd[i] = 0; c_nph[i] = 0; c_npd[i] = 0; x_err[i] = 0; busy[i] = 0;
        end
        din16 = 0; din64 = 0;
        @(negedge clk);
        do_reset();
        send(0, 8'h40, 7'b0000100, 10'd10, 4, 0);
        chk("mwr_ph", 32'(o_ph[0]), 1);
        chk("mwr_pd", 32'(o_pd[0]), 3);
        chk("mwr_valid", 32'(o_valid[0]), 1);
        do_reset();
        send(0, 8'h00, 7'b0000001, 10'd4, 3, 0);
        chk("mrd_masked_valid", 32'(o_valid[0]), 0);
        send(0, 8'h00, 7'b0001000, 10'd4, 3, 0);
        chk("mrd_nph", 32'(o_nph[0]), 1);
        send(1, 8'h70, 7'd0, 10'd0, 2, 0);
        chk("msgd_ph", 32'(o_ph[1]), 1);
        chk("msgd_pd", 32'(o_pd[1]), 256);
        send(1, 8'h44, 7'd0, 10'd1, 1, 0);
        chk("cfgwr_nph", 32'(o_nph[1]), 1);
        chk("cfgwr_npd", 32'(o_npd[1]), 1);
        do_reset();
        for (int k = 0; k < 3; k++) send(0, 8'h04, 7'd0, 10'd1, 2, 0);
        chk("pre_hs_nph", 32'(o_nph[0]), 3);
        rmode = 3;
        send(0, 8'h04, 7'd0, 10'd1, 3, 0);
        chk("hs_nph", 32'(o_nph[0]), 1);
        rmode = 0;
        do_reset();
        for (int k = 0; k < 300; k++) send(0, 8'h30, 7'd0, 10'd0, 1, 0);
        chk("sat_ph", 32'(o_ph[0]), 255);
        chk("sat_ovf", 32'(o_ovf[0]), 1);
        send(1, 8'h40, 7'd0, 10'd8, 2, 1);
        send(1, 8'h04, 7'd0, 10'd0, 2, 0);
        chk("abort_ph", 32'(o_ph[1]), 0);
        chk("abort_pd", 32'(o_pd[1]), 0);
        chk("abort_nph", 32'(o_nph[1]), 1);
        send(0, 8'h40, 7'd0, 10'd5, 3, 1);
        do_reset();
        stray(0);
        chk("rst_stray_err", 32'(o_err[0]), 1);
        do_reset();
        rmode = 1;
        rand_phase();
        rmode = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
